// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Build option: UART_TX_ARB_RR_EN selects round-robin tie breaking.
package uart_tx_arb_pkg;

    // Arbiter state encoding. Also driven out on the debug port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Requester indices. These are also the bit positions in grant.
    localparam int REQ_PONG = 0;
    localparam int REQ_DUMP = 1;

    // An 8N1 frame is one start bit, eight data bits and one stop bit.
    localparam int FRAME_BITS = 10;

    // Build the on-wire frame. Bit 0 goes out first.
    function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_core.sv
// 8N1 UART shifter: baud counter plus a 10-bit frame shift register.
// A load pulse starts a frame while the core is idle. done pulses during
// the last cycle of the stop bit. bit_end marks the last cycle of every bit.
module uart_tx_core
    import uart_tx_arb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       serial_out,
    output logic       bit_end,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    logic [BAUD_W-1:0]     baud_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  active;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    assign done    = bit_end && (bit_cnt == BIT_LAST);

    // Shift one frame out. serial_out is registered and always equals shreg[0]
    // of the bit currently on the wire, or 1 while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '1;
            active     <= 1'b0;
            serial_out <= 1'b1;
        end else if (load) begin
            shreg      <= frame_bits(data);
            serial_out <= 1'b0;
            active     <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (done) begin
                    active     <= 1'b0;
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                end else begin
                    bit_cnt    <= bit_cnt + 4'd1;
                    shreg      <= {1'b1, shreg[FRAME_BITS-1:1]};
                    serial_out <= shreg[1];
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet arbiter that shares one UART transmitter between the pong
// responder and the ADC dump path.
// Build option: define UART_TX_ARB_RR_EN for round-robin tie breaking.
// Without it, pong always wins ties.
//
// Handshake: a byte moves on any cycle where valid && ready are both high.
// Ready is combinational. It is high only in IDLE (for the arbitration
// winner among the valid requesters) or in HOLD (for the lock owner). At most
// one ready is high in any cycle. Requesters must keep valid, data and last
// stable until the byte is accepted.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int HOLD_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pong_valid,
    input  logic [7:0] pong_data,
    input  logic       pong_last,
    output logic       pong_ready,
    input  logic       dump_valid,
    input  logic [7:0] dump_data,
    input  logic       dump_last,
    output logic       dump_ready,
    output logic       serial_out,
    output logic [1:0] grant,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int HOLD_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    state_t            state;
    logic              last_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [2:0]        data_cnt;

    logic       prefer_dump;
    logic       pong_win_idle;
    logic       dump_win_idle;
    logic       acc_pong;
    logic       acc_dump;
    logic       accept;
    logic       acc_last;
    logic [7:0] load_data;
    logic       core_bit_end;
    logic       core_done;

    assign dbg_state = state;

`ifdef UART_TX_ARB_RR_EN
    // Index of the requester that won the last acceptance. It resets to dump,
    // so pong wins the first tie.
    logic last_winner;
    assign prefer_dump = (last_winner == 1'(REQ_PONG));
`else
    assign prefer_dump = 1'b0;
`endif

    // Decide the IDLE winner among the requesters that are currently valid.
    assign pong_win_idle = pong_valid && !(dump_valid && prefer_dump);
    assign dump_win_idle = dump_valid && !(pong_valid && !prefer_dump);

    // Drive the ready outputs: the IDLE winner, or the lock owner while in HOLD.
    always_comb begin
        pong_ready = 1'b0;
        dump_ready = 1'b0;
        case (state)
            IDLE: begin
                pong_ready = pong_win_idle;
                dump_ready = dump_win_idle;
            end
            HOLD: begin
                pong_ready = grant[REQ_PONG];
                dump_ready = grant[REQ_DUMP];
            end
            default: begin
                pong_ready = 1'b0;
                dump_ready = 1'b0;
            end
        endcase
    end

    assign acc_pong  = pong_valid && pong_ready;
    assign acc_dump  = dump_valid && dump_ready;
    assign accept    = acc_pong || acc_dump;
    assign acc_last  = acc_dump ? dump_last : pong_last;
    assign load_data = acc_dump ? dump_data : pong_data;

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .data       (load_data),
        .serial_out (serial_out),
        .bit_end    (core_bit_end),
        .done       (core_done)
    );

    // Main FSM: arbitration, packet lock, hold timeout and frame phase tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 2'b00;
            busy     <= 1'b0;
            last_q   <= 1'b0;
            hold_cnt <= '0;
            data_cnt <= '0;
`ifdef UART_TX_ARB_RR_EN
            last_winner <= 1'(REQ_DUMP);
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        // An accept in HOLD also covers the timeout cycle.
                        // The byte takes priority and the lock is kept.
                        state    <= START;
                        grant    <= {acc_dump, acc_pong};
                        busy     <= 1'b1;
                        last_q   <= acc_last;
                        hold_cnt <= '0;
`ifdef UART_TX_ARB_RR_EN
                        last_winner <= acc_dump;
`endif
                    end else if (state == HOLD) begin
                        if (hold_cnt >= HOLD_LAST) begin
                            state    <= IDLE;
                            grant    <= 2'b00;
                            hold_cnt <= '0;
                        end else if (hold_cnt != '1) begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                START: begin
                    if (core_bit_end) begin
                        state    <= DATA;
                        data_cnt <= '0;
                    end
                end
                DATA: begin
                    if (core_bit_end) begin
                        if (data_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            data_cnt <= data_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (core_done) begin
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        if (last_q) begin
                            state <= IDLE;
                            grant <= 2'b00;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with CLKS_PER_BIT=4 and HOLD_TIMEOUT=20.
module tb_uart_tx_arbiter;
    import uart_tx_arb_pkg::*;

    localparam int CPB = 4;
    localparam int HT  = 20;

    logic       clk;
    logic       rst;
    logic       pong_valid;
    logic [7:0] pong_data;
    logic       pong_last;
    logic       pong_ready;
    logic       dump_valid;
    logic [7:0] dump_data;
    logic       dump_last;
    logic       dump_ready;
    logic       serial_out;
    logic [1:0] grant;
    logic       busy;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .CLKS_PER_BIT (CPB),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pong_valid (pong_valid),
        .pong_data  (pong_data),
        .pong_last  (pong_last),
        .pong_ready (pong_ready),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .dump_ready (dump_ready),
        .serial_out (serial_out),
        .grant      (grant),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start this task one cycle after acceptance. It checks every cycle of the
    // 10-bit frame and returns on the first cycle after the stop bit.
    task automatic frame(input logic [7:0] d, input logic [1:0] g, input string tag);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                #1;
                check({tag, ".serial"}, 32'(serial_out), 32'(f[b]));
                check({tag, ".grant"}, 32'(grant), 32'(g));
                check({tag, ".busy"}, 32'(busy), 32'd1);
                check({tag, ".pong_rdy"}, 32'(pong_ready), 32'd0);
                check({tag, ".dump_rdy"}, 32'(dump_ready), 32'd0);
                tick();
            end
        end
    endtask

    initial begin
        logic [9:0] a5_wire;
        rst = 1'b1;
        pong_valid = 1'b0; pong_data = 8'h00; pong_last = 1'b0;
        dump_valid = 1'b0; dump_data = 8'h00; dump_last = 1'b0;
        tick(); tick();
        #1;
        check("rst.serial", 32'(serial_out), 32'd1);
        check("rst.grant", 32'(grant), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.pong_rdy", 32'(pong_ready), 32'd0);
        check("rst.dump_rdy", 32'(dump_ready), 32'd0);
        check("rst.state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // 1: single pong byte 0xA5. The bit order 0,1,0,1,0,0,1,0,1,1 was worked out by hand.
        a5_wire = 10'b11_0100_1010;
        check("a5.wire_const", 32'({1'b1, 8'hA5, 1'b0}), 32'(a5_wire));
        pong_valid = 1'b1; pong_data = 8'hA5; pong_last = 1'b1;
        #1;
        check("s1.pong_rdy", 32'(pong_ready), 32'd1);
        tick();
        pong_valid = 1'b0;
        frame(8'hA5, 2'b01, "s1");
        #1;
        check("s1.grant_end", 32'(grant), 32'd0);
        check("s1.busy_end", 32'(busy), 32'd0);
        check("s1.state_end", 32'(dbg_state), 32'(IDLE));
        tick();

        // 2: tie in IDLE. Pong wins, then dump follows.
        pong_valid = 1'b1; pong_data = 8'h55; pong_last = 1'b1;
        dump_valid = 1'b1; dump_data = 8'h0F; dump_last = 1'b1;
        #1;
        check("s2.pong_rdy", 32'(pong_ready), 32'd1);
        check("s2.dump_rdy", 32'(dump_ready), 32'd0);
        tick();
        pong_valid = 1'b0;
        frame(8'h55, 2'b01, "s2p");
        #1;
        check("s2.dump_rdy_after", 32'(dump_ready), 32'd1);
        check("s2.grant_gap", 32'(grant), 32'd0);
        tick();
        dump_valid = 1'b0;
        frame(8'h0F, 2'b10, "s2d");
        #1;
        check("s2.grant_end", 32'(grant), 32'd0);
        tick();

        // 3: dump packet 0x11,0x22. Pong arrives mid-packet and has to wait.
        dump_valid = 1'b1; dump_data = 8'h11; dump_last = 1'b0;
        #1;
        check("s3.dump_rdy", 32'(dump_ready), 32'd1);
        tick();
        dump_data = 8'h22; dump_last = 1'b1;
        pong_valid = 1'b1; pong_data = 8'h77; pong_last = 1'b1;
        frame(8'h11, 2'b10, "s3a");
        #1;
        check("s3.hold_state", 32'(dbg_state), 32'(HOLD));
        check("s3.hold_grant", 32'(grant), 32'd2);
        check("s3.hold_pong_rdy", 32'(pong_ready), 32'd0);
        check("s3.hold_dump_rdy", 32'(dump_ready), 32'd1);
        tick();
        dump_valid = 1'b0;
        frame(8'h22, 2'b10, "s3b");
        #1;
        check("s3.grant_free", 32'(grant), 32'd0);
        check("s3.pong_rdy", 32'(pong_ready), 32'd1);
        tick();
        pong_valid = 1'b0;
        frame(8'h77, 2'b01, "s3c");

        // 4: dump 0x33 with last=0, then silence. The lock drops after 20 HOLD cycles.
        dump_valid = 1'b1; dump_data = 8'h33; dump_last = 1'b0;
        #1;
        check("s4.dump_rdy", 32'(dump_ready), 32'd1);
        tick();
        dump_valid = 1'b0;
        frame(8'h33, 2'b10, "s4a");
        pong_valid = 1'b1; pong_data = 8'h44; pong_last = 1'b1;
        for (int i = 0; i < HT; i++) begin
            #1;
            check("s4.hold_grant", 32'(grant), 32'd2);
            check("s4.hold_state", 32'(dbg_state), 32'(HOLD));
            check("s4.hold_pong_rdy", 32'(pong_ready), 32'd0);
            tick();
        end
        #1;
        check("s4.to_grant", 32'(grant), 32'd0);
        check("s4.to_state", 32'(dbg_state), 32'(IDLE));
        check("s4.pong_rdy", 32'(pong_ready), 32'd1);
        tick();
        pong_valid = 1'b0;
        frame(8'h44, 2'b01, "s4b");

        // 5: reset during data bit 3 of 0xC3 (that bit is 0 on the wire).
        pong_valid = 1'b1; pong_data = 8'hC3; pong_last = 1'b1;
        tick();
        pong_valid = 1'b0;
        repeat (1 + CPB * 4) tick();
        #1;
        check("s5.bit3", 32'(serial_out), 32'd0);
        check("s5.grant_pre", 32'(grant), 32'd1);
        rst = 1'b1;
        #1;
        check("s5.rst_serial", 32'(serial_out), 32'd1);
        check("s5.rst_grant", 32'(grant), 32'd0);
        check("s5.rst_busy", 32'(busy), 32'd0);
        check("s5.rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst = 1'b0;
        tick();
        dump_valid = 1'b1; dump_data = 8'h96; dump_last = 1'b1;
        #1;
        check("s5.dump_rdy", 32'(dump_ready), 32'd1);
        tick();
        dump_valid = 1'b0;
        frame(8'h96, 2'b10, "s5");

        // 6: the owner's valid arrives exactly on the timeout cycle, with pong also pending.
        dump_valid = 1'b1; dump_data = 8'h5A; dump_last = 1'b0;
        tick();
        dump_valid = 1'b0;
        frame(8'h5A, 2'b10, "s6a");
        repeat (HT - 1) tick();
        dump_valid = 1'b1; dump_data = 8'hA3; dump_last = 1'b1;
        pong_valid = 1'b1; pong_data = 8'hEE; pong_last = 1'b1;
        #1;
        check("s6.edge_state", 32'(dbg_state), 32'(HOLD));
        check("s6.edge_dump_rdy", 32'(dump_ready), 32'd1);
        check("s6.edge_pong_rdy", 32'(pong_ready), 32'd0);
        tick();
        dump_valid = 1'b0;
        frame(8'hA3, 2'b10, "s6b");
        #1;
        check("s6.grant_free", 32'(grant), 32'd0);
        check("s6.pong_rdy", 32'(pong_ready), 32'd1);
        tick();
        pong_valid = 1'b0;
        frame(8'hEE, 2'b01, "s6c");
        #1;
        check("s6.final_state", 32'(dbg_state), 32'(IDLE));
        check("s6.final_serial", 32'(serial_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
